branch_predictor_ctrl: RTL

// - Dynamic branch predictor and redirect controller for the 5-stage pipe. Predicts branch/jump outcome and target in IF

---
 rtl/branch_predictor_ctrl_pkg.sv | 15 +
 rtl/branch_predictor_ctrl_if.sv | 32 +++
 rtl/branch_predictor_ctrl_sat_counter2.sv | 24 ++
 rtl/branch_predictor_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/branch_predictor_ctrl_pkg.sv
// branch_predictor_ctrl_pkg: shared constants, opcode codes and FSM encoding for the branch predictor
package branch_predictor_ctrl_pkg;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 16;
    localparam logic [1:0] CTR_RST   = 2'b01;
    localparam logic [1:0] CTR_TAKEN = 2'b10;
    localparam logic [2:0] OP_JUMP = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;
    localparam logic [2:0] OP_BGE  = 3'd4;
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;
endpackage

// File: rtl/branch_predictor_ctrl_if.sv
// branch_predictor_ctrl_if: fetch/resolve/maintenance signals between the pipe and the predictor
interface branch_predictor_ctrl_if;
    import branch_predictor_ctrl_pkg::*;
    logic             IF_valid;
    logic [31:0]      IF_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ID_valid;
    logic             ID_is_branch;
    logic [31:0]      ID_pc;
    logic             ID_pred_taken;
    logic [31:0]      ID_pred_target;
    logic             ID_actual_taken;
    logic [31:0]      ID_actual_target;
    logic             redirect;
    logic [31:0]      redirect_addr;
    logic             IFID_flush;
    logic             inval_req;
    logic             busy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    modport slave (
        input  IF_valid, IF_pc, ID_valid, ID_is_branch, ID_pc, ID_pred_taken, ID_pred_target,
               ID_actual_taken, ID_actual_target, inval_req,
        output pred_taken, pred_target, redirect, redirect_addr, IFID_flush, busy, branch_cnt, mispred_cnt
    );
    modport master (
        output IF_valid, IF_pc, ID_valid, ID_is_branch, ID_pc, ID_pred_taken, ID_pred_target,
               ID_actual_taken, ID_actual_target, inval_req,
        input  pred_taken, pred_target, redirect, redirect_addr, IFID_flush, busy, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_ctrl_sat_counter2.sv
// sat_counter2: 2-bit up/down saturating counter with sync clear and load
module sat_counter2
    import branch_predictor_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic [1:0] ld_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] ctr_o
);
    logic [1:0] ctr_q, ctr_d;
    // next value: clear beats load beats count, counting stops at 0 and 3
    always_comb ctr_d = clr_i ? CTR_RST : ld_i ? ld_val_i :
                        (inc_i && ctr_q != 2'b11) ? ctr_q + 2'd1 :
                        (dec_i && ctr_q != 2'b00) ? ctr_q - 2'd1 : ctr_q;
    // counter register, weak not-taken out of reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ctr_q <= CTR_RST;
        else ctr_q <= ctr_d;
    assign ctr_o = ctr_q;
endmodule

// File: rtl/branch_predictor_ctrl.sv
// branch_predictor_ctrl: 2-bit counter + BTB predictor with ID-stage redirect and table invalidate sweep
module branch_predictor_ctrl
    import branch_predictor_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predictor_ctrl_if.slave bp
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] br_q, br_d, mp_q, mp_d;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [31:0]      tgt_q [ENTRIES];
    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] if_idx, id_idx;
    logic [TAG_W-1:0] if_tag, id_tag;
    logic             idle, fire, mis, upd, id_hit, wr;
    assign if_idx = bp.IF_pc[IDX_W+1:2];
    assign if_tag = bp.IF_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign id_idx = bp.ID_pc[IDX_W+1:2];
    assign id_tag = bp.ID_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign idle   = state_q == IDLE;
    assign fire   = bp.ID_valid & bp.ID_is_branch;
    assign mis    = fire & ((bp.ID_pred_taken != bp.ID_actual_taken) |
                    (bp.ID_pred_taken & bp.ID_actual_taken & (bp.ID_pred_target != bp.ID_actual_target)));
    assign upd    = fire & idle;
    assign id_hit = valid_q[id_idx] && tag_q[id_idx] == id_tag;
    assign wr     = upd & bp.ID_actual_taken;
    assign bp.pred_taken    = bp.IF_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag) & ctr[if_idx][1] & idle;
    assign bp.pred_target   = bp.pred_taken ? tgt_q[if_idx] : bp.IF_pc + 32'd4;
    assign bp.redirect      = mis;
    assign bp.IFID_flush    = mis;
    assign bp.redirect_addr = (mis & bp.ID_actual_taken) ? bp.ID_actual_target : bp.ID_pc + 32'd4;
    assign bp.busy          = !idle;
    assign bp.branch_cnt    = br_q;
    assign bp.mispred_cnt   = mp_q;
    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_ctr
            sat_counter2 u_ctr (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (!idle && ptr_q == IDX_W'(i)),
                .ld_i     (wr && id_idx == IDX_W'(i) && !id_hit),
                .ld_val_i (CTR_TAKEN),
                .inc_i    (upd && bp.ID_actual_taken && id_hit && id_idx == IDX_W'(i)),
                .dec_i    (upd && !bp.ID_actual_taken && id_hit && id_idx == IDX_W'(i)),
                .ctr_o    (ctr[i])
            );
        end
    endgenerate
    // sweep sequencing and saturating perf counters
    always_comb begin
        state_d = idle ? (bp.inval_req ? SWEEP : IDLE) : (&ptr_q ? IDLE : SWEEP);
        ptr_d   = idle ? '0 : ptr_q + IDX_W'(1);
        br_d    = (fire && !(&br_q)) ? br_q + CNT_W'(1) : br_q;
        mp_d    = (mis && !(&mp_q)) ? mp_q + CNT_W'(1) : mp_q;
    end
    // state, sweep pointer and counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            br_q    <= '0;
            mp_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
        end
    // valid/tag/target table: taken resolutions allocate, the sweep invalidates
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                tag_q[k] <= '0;
                tgt_q[k] <= '0;
            end
        end else begin
            if (!idle) valid_q[ptr_q] <= 1'b0;
            if (wr) begin
                valid_q[id_idx] <= 1'b1;
                tag_q[id_idx]   <= id_tag;
                tgt_q[id_idx]   <= bp.ID_actual_target;
            end
        end
endmodule
